// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing the SD command-issue path between software (SW) and the data master (DM).
// Optional WAIT_BUSY timeout abort is compiled in with `define SD_ARB_TIMEOUT_EN.
module sd_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CNT_W   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_req,
    input  logic [15:0] sw_cmd_set,
    input  logic [31:0] sw_cmd_arg,
    output logic        sw_ack,
    output logic        sw_done,
    input  logic        dm_req,
    input  logic [15:0] dm_cmd_set,
    input  logic [31:0] dm_cmd_arg,
    output logic        dm_ack,
    output logic        dm_done,
    output logic [15:0] cmd_set_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_start,
    input  logic        cmd_busy,
    input  logic        cmd_tsf_err,
    output logic        cmd_err,
    output logic        owner,
    output logic        busy_o,
    output logic        timeout_o
);

    if (TIMEOUT < 2 || (TIMEOUT >> CNT_W) != 0) begin : g_param_err
        $error("sd_cmd_arbiter: TIMEOUT must be >= 2 and < 2**CNT_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        last, last_nxt;
    logic        owner_nxt;
    logic [15:0] set_nxt;
    logic [31:0] arg_nxt;
    logic        sw_ack_nxt, dm_ack_nxt;
    logic        sw_done_nxt, dm_done_nxt;
    logic        start_nxt;
    logic        err_nxt;
    logic        grant_sw, grant_dm;

`ifdef SD_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_nxt;
`endif

    // last = 0 (SW) gives DM the tie, last = 1 (DM) gives SW the tie
    assign grant_dm = dm_req && (!sw_req || !last);
    assign grant_sw = sw_req && (!dm_req ||  last);

    assign busy_o = (state != ST_IDLE);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        owner_nxt   = owner;
        set_nxt     = cmd_set_o;
        arg_nxt     = cmd_arg_o;
        sw_ack_nxt  = 1'b0;
        dm_ack_nxt  = 1'b0;
        sw_done_nxt = 1'b0;
        dm_done_nxt = 1'b0;
        start_nxt   = 1'b0;
        err_nxt     = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (grant_dm) begin
                    owner_nxt  = 1'b1;
                    set_nxt    = dm_cmd_set;
                    arg_nxt    = dm_cmd_arg;
                    dm_ack_nxt = 1'b1;
                    state_nxt  = ST_ISSUE;
                end else if (grant_sw) begin
                    owner_nxt  = 1'b0;
                    set_nxt    = sw_cmd_set;
                    arg_nxt    = sw_cmd_arg;
                    sw_ack_nxt = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_nxt = 1'b1;
`ifdef SD_ARB_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (cmd_busy) begin
                    state_nxt = ST_WAIT_DONE;
`ifdef SD_ARB_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt   = ST_DONE;
                    sw_done_nxt = !owner;
                    dm_done_nxt = owner;
                    err_nxt     = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (!cmd_busy) begin
                    state_nxt   = ST_DONE;
                    sw_done_nxt = !owner;
                    dm_done_nxt = owner;
                    err_nxt     = cmd_tsf_err;
                end
            end
            ST_DONE: begin
                last_nxt  = owner;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= 1'b0;
            owner     <= 1'b0;
            cmd_set_o <= '0;
            cmd_arg_o <= '0;
            sw_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            sw_done   <= 1'b0;
            dm_done   <= 1'b0;
            cmd_start <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            cmd_set_o <= set_nxt;
            cmd_arg_o <= arg_nxt;
            sw_ack    <= sw_ack_nxt;
            dm_ack    <= dm_ack_nxt;
            sw_done   <= sw_done_nxt;
            dm_done   <= dm_done_nxt;
            cmd_start <= start_nxt;
            cmd_err   <= err_nxt;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            timeout_o <= timeout_nxt;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: stimulus queues expected acks/starts/dones, a negedge monitor checks them.
// Honours SD_ARB_TIMEOUT_EN to select the expected timeout behaviour.
module tb_sd_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        sw_req, dm_req;
    logic [15:0] sw_cmd_set, dm_cmd_set;
    logic [31:0] sw_cmd_arg, dm_cmd_arg;
    logic        sw_ack, sw_done, dm_ack, dm_done;
    logic [15:0] cmd_set_o;
    logic [31:0] cmd_arg_o;
    logic        cmd_start, cmd_busy, cmd_tsf_err;
    logic        cmd_err, owner, busy_o, timeout_o;

    logic        host_on = 1'b0;
    int          host_len = 3;
    logic        host_err = 1'b0;
    logic        host_busy = 1'b0, host_tsf = 1'b0;
    logic        man_busy = 1'b0, man_tsf = 1'b0;

    assign cmd_busy    = host_busy | man_busy;
    assign cmd_tsf_err = host_tsf | man_tsf;

    always #5 clk = ~clk;

    sd_cmd_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .sw_req(sw_req), .sw_cmd_set(sw_cmd_set), .sw_cmd_arg(sw_cmd_arg),
        .sw_ack(sw_ack), .sw_done(sw_done),
        .dm_req(dm_req), .dm_cmd_set(dm_cmd_set), .dm_cmd_arg(dm_cmd_arg),
        .dm_ack(dm_ack), .dm_done(dm_done),
        .cmd_set_o(cmd_set_o), .cmd_arg_o(cmd_arg_o), .cmd_start(cmd_start),
        .cmd_busy(cmd_busy), .cmd_tsf_err(cmd_tsf_err), .cmd_err(cmd_err),
        .owner(owner), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    typedef struct packed { logic who; logic [15:0] set; logic [31:0] arg; } xact_t;
    typedef struct packed { logic who; logic err; logic to; } done_t;

    xact_t ack_q[$], start_q[$];
    done_t done_q[$];
    int    n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Command host model: answers each start with busy for host_len cycles
    initial begin
        forever begin
            @(negedge clk);
            if (host_on && cmd_start) begin
                host_busy = 1'b1;
                repeat (host_len) @(negedge clk);
                host_tsf  = host_err;
                host_busy = 1'b0;
                @(negedge clk);
                host_tsf  = 1'b0;
            end
        end
    end

    xact_t mx;
    done_t md;
    always @(negedge clk) begin
        if (sw_ack || dm_ack) begin
            if (ack_q.size() == 0) check("unexpected_ack", {dm_ack, sw_ack}, 2'b00);
            else begin
                mx = ack_q.pop_front();
                check("ack_who", {dm_ack, sw_ack}, mx.who ? 2'b10 : 2'b01);
                check("ack_set", cmd_set_o, mx.set);
                check("ack_arg", cmd_arg_o, mx.arg);
            end
        end
        if (cmd_start) begin
            if (start_q.size() == 0) check("unexpected_start", cmd_start, 1'b0);
            else begin
                mx = start_q.pop_front();
                check("start_owner", owner, mx.who);
                check("start_set", cmd_set_o, mx.set);
                check("start_arg", cmd_arg_o, mx.arg);
            end
        end
        if (sw_done || dm_done) begin
            if (done_q.size() == 0) check("unexpected_done", {dm_done, sw_done}, 2'b00);
            else begin
                md = done_q.pop_front();
                check("done_who", {dm_done, sw_done}, md.who ? 2'b10 : 2'b01);
                check("done_err", cmd_err, md.err);
                check("done_timeout", timeout_o, md.to);
            end
        end else if (cmd_err || timeout_o) begin
            check("err_without_done", {cmd_err, timeout_o}, 2'b00);
        end
    end

    task automatic wait_idle();
        logic got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o) begin got = 1'b1; break; end
        end
        if (!got) check("idle_timeout", busy_o, 1'b0);
    endtask

    task automatic wait_start();
        logic got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_start) begin got = 1'b1; break; end
        end
        if (!got) check("start_timeout", cmd_start, 1'b1);
    endtask

    task automatic expect_xact(input logic who, input logic [15:0] set, input logic [31:0] arg,
                               input logic err, input logic to, input logic push_done);
        xact_t x;
        done_t d;
        x = '{who, set, arg};
        ack_q.push_back(x);
        start_q.push_back(x);
        d = '{who, err, to};
        if (push_done) done_q.push_back(d);
    endtask

    task automatic issue(input logic who, input logic [15:0] set, input logic [31:0] arg,
                         input logic err, input logic to, input logic push_done);
        logic got = 1'b0;
        expect_xact(who, set, arg, err, to, push_done);
        @(negedge clk);
        if (who) begin dm_req = 1'b1; dm_cmd_set = set; dm_cmd_arg = arg; end
        else     begin sw_req = 1'b1; sw_cmd_set = set; sw_cmd_arg = arg; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (who ? dm_ack : sw_ack) begin got = 1'b1; break; end
        end
        if (!got) check("ack_timeout", who ? dm_ack : sw_ack, 1'b1);
        sw_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic both_req(input logic [15:0] dset, input logic [15:0] sset);
        logic dm_pend, sw_pend;
        expect_xact(1'b1, dset, 32'hD000_0000 | 32'(dset), 1'b0, 1'b0, 1'b1);
        expect_xact(1'b0, sset, 32'h5000_0000 | 32'(sset), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        dm_req = 1'b1; dm_cmd_set = dset; dm_cmd_arg = 32'hD000_0000 | 32'(dset);
        sw_req = 1'b1; sw_cmd_set = sset; sw_cmd_arg = 32'h5000_0000 | 32'(sset);
        dm_pend = 1'b1;
        sw_pend = 1'b1;
        for (int i = 0; i < 200 && (dm_pend || sw_pend); i++) begin
            @(negedge clk);
            if (dm_ack) begin dm_req = 1'b0; dm_pend = 1'b0; end
            if (sw_ack) begin sw_req = 1'b0; sw_pend = 1'b0; end
        end
        if (dm_pend || sw_pend) check("both_ack_timeout", {dm_pend, sw_pend}, 2'b00);
        dm_req = 1'b0;
        sw_req = 1'b0;
        wait_idle();
    endtask

    function automatic logic [8:0] flags();
        return {sw_ack, sw_done, dm_ack, dm_done, cmd_start, cmd_err, owner, busy_o, timeout_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sw_req = 1'b0; dm_req = 1'b0;
        sw_cmd_set = '0; sw_cmd_arg = '0; dm_cmd_set = '0; dm_cmd_arg = '0;
        repeat (3) @(negedge clk);
        check("reset_flags", flags(), 9'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_flags", flags(), 9'd0);
        check("post_reset_data", {cmd_set_o, cmd_arg_o}, 48'd0);

        // Simultaneous requests from reset: DM first, then SW; repeated after SW was last
        host_on = 1'b1; host_len = 2; host_err = 1'b0;
        both_req(16'h1111, 16'h5555);
        both_req(16'h2222, 16'h6666);

        // SW alone with exact latency checks
        host_len = 3;
        expect_xact(1'b0, 16'h081A, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        sw_req = 1'b1; sw_cmd_set = 16'h081A; sw_cmd_arg = 32'h1234_5678;
        @(negedge clk);
        check("t1_ack_cycle", {sw_ack, cmd_start}, 2'b10);
        sw_req = 1'b0;
        @(negedge clk);
        check("t1_start_cycle", {sw_ack, cmd_start}, 2'b01);
        check("t1_cmd_set", cmd_set_o, 16'h081A);
        wait_idle();
        check("t1_hold_set", cmd_set_o, 16'h081A);

        // DM transfer error, then a clean SW command
        host_len = 2; host_err = 1'b1;
        issue(1'b1, 16'h111A, 32'hAAAA_0001, 1'b1, 1'b0, 1'b1);
        wait_idle();
        host_err = 1'b0;
        issue(1'b0, 16'h0333, 32'h0000_0333, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Busy already high when start fires
        host_on = 1'b0;
        man_busy = 1'b1;
        issue(1'b0, 16'h0C0D, 32'hC0C0_D0D0, 1'b0, 1'b0, 1'b1);
        wait_start();
        @(negedge clk);
        check("t6_hold", {busy_o, sw_done}, 2'b10);
        man_busy = 1'b0;
        @(negedge clk);
        check("t6_done", sw_done, 1'b1);
        @(negedge clk);
        check("t6_done_clear", {sw_done, cmd_err}, 2'b00);
        wait_idle();

        // Busy never rises
`ifdef SD_ARB_TIMEOUT_EN
        issue(1'b1, 16'h0D0D, 32'h0000_0D0D, 1'b1, 1'b1, 1'b1);
        wait_start();
        repeat (7) @(negedge clk);
        check("t4_no_early_done", dm_done, 1'b0);
        @(negedge clk);
        check("t4_timeout_done", {dm_done, timeout_o, cmd_err}, 3'b111);
        wait_idle();
`else
        issue(1'b1, 16'h0D0D, 32'h0000_0D0D, 1'b0, 1'b0, 1'b0);
        wait_start();
        repeat (40) @(negedge clk);
        check("t4_still_busy", {busy_o, dm_done, timeout_o}, 3'b100);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        // Reset while in WAIT_DONE, then a normal SW command
        host_on = 1'b1; host_len = 10;
        issue(1'b0, 16'h0505, 32'h0505_0505, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !cmd_busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t5_in_wait_done", busy_o, 1'b1);
        #2 rst = 1'b1;
        #1 check("t5_reset_flags", flags(), 9'd0);
        check("t5_reset_data", {cmd_set_o, cmd_arg_o}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30 && cmd_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        host_len = 2;
        issue(1'b0, 16'h0606, 32'h0606_0606, 1'b0, 1'b0, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        check("ack_q_left", 64'(ack_q.size()), 64'd0);
        check("start_q_left", 64'(start_q.size()), 64'd0);
        check("done_q_left", 64'(done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
